// File: rtl/rgb_sequencer.sv
// RGB LED pattern sequencer: OFF, SOLID, RAINBOW and BLINK patterns selected by a valid/ready
// command. All outputs are registered and follow the state register by one cycle.
module rgb_sequencer #(
   parameter int unsigned CLK_HZ        = 12000000,
   parameter int unsigned DWELL_W       = 24,
   parameter int unsigned DWELL_DEFAULT = CLK_HZ
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_mode,
   input  logic [2:0]         cmd_color,
   input  logic [DWELL_W-1:0] cmd_dwell,
   output logic               RGB_R,
   output logic               RGB_G,
   output logic               RGB_B,
   output logic               step
);

   typedef enum logic [2:0] {
      StOff,
      StLoad,
      StSolid,
      StRainbow,
      StBlinkOn,
      StBlinkOff
   } state_e;

   localparam logic [1:0] ModeOff     = 2'd0;
   localparam logic [1:0] ModeSolid   = 2'd1;
   localparam logic [1:0] ModeRainbow = 2'd2;
   localparam logic [1:0] ModeBlink   = 2'd3;

   localparam logic [DWELL_W-1:0] DwellOne = {{(DWELL_W-1){1'b0}}, 1'b1};
   localparam logic [DWELL_W-1:0] DwellRst = DWELL_W'(DWELL_DEFAULT);

   function automatic logic [2:0] rainbow_color(input logic [2:0] idx);
      logic [2:0] col;
      case (idx)
         3'd0:    col = 3'b100;
         3'd1:    col = 3'b110;
         3'd2:    col = 3'b010;
         3'd3:    col = 3'b011;
         3'd4:    col = 3'b001;
         3'd5:    col = 3'b101;
         default: col = 3'b000;
      endcase
      return col;
   endfunction

   state_e             state_q, state_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [2:0]         idx_q, idx_d;
   logic [1:0]         mode_q, mode_d;
   logic [2:0]         color_q, color_d;
   logic [2:0]         rgb_q, rgb_d;
   logic               step_q, step_d;
   logic               ready_q, ready_d;
   logic               adv_q, adv_d;

   logic               accept;
   logic               terminal;
   logic [DWELL_W-1:0] dwell_m1;

   always_comb begin
      accept   = cmd_valid && ready_q;
      // A dwell of 0 behaves like 1: terminal count is reached on every counted cycle.
      dwell_m1 = (dwell_q == '0) ? '0 : dwell_q - DwellOne;
      terminal = (cnt_q == dwell_m1);

      state_d = state_q;
      cnt_d   = cnt_q;
      dwell_d = dwell_q;
      idx_d   = idx_q;
      mode_d  = mode_q;
      color_d = color_q;
      ready_d = !accept;
      adv_d   = 1'b0;
      step_d  = adv_q;

      unique case (state_q)
         StOff, StBlinkOff: rgb_d = 3'b000;
         StSolid, StBlinkOn: rgb_d = color_q;
         StRainbow:          rgb_d = rainbow_color(idx_q);
         default:            rgb_d = rgb_q;
      endcase

      // An accept preempts everything, including a terminal count on the same edge.
      if (accept) begin
         state_d = StLoad;
         mode_d  = cmd_mode;
         color_d = cmd_color;
         dwell_d = cmd_dwell;
      end else begin
         unique case (state_q)
            StLoad: begin
               cnt_d = '0;
               idx_d = 3'd0;
               unique case (mode_q)
                  ModeOff:     state_d = StOff;
                  ModeSolid:   state_d = StSolid;
                  ModeRainbow: state_d = StRainbow;
                  ModeBlink:   state_d = StBlinkOn;
                  default:     state_d = StOff;
               endcase
            end
            StRainbow: begin
               if (terminal) begin
                  cnt_d = '0;
                  adv_d = 1'b1;
                  idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
               end else begin
                  cnt_d = cnt_q + DwellOne;
               end
            end
            StBlinkOn, StBlinkOff: begin
               if (terminal) begin
                  cnt_d   = '0;
                  adv_d   = 1'b1;
                  state_d = (state_q == StBlinkOn) ? StBlinkOff : StBlinkOn;
               end else begin
                  cnt_d = cnt_q + DwellOne;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StOff;
         cnt_q   <= '0;
         dwell_q <= DwellRst;
         idx_q   <= 3'd0;
         mode_q  <= ModeOff;
         color_q <= 3'b000;
         rgb_q   <= 3'b000;
         step_q  <= 1'b0;
         ready_q <= 1'b0;
         adv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dwell_q <= dwell_d;
         idx_q   <= idx_d;
         mode_q  <= mode_d;
         color_q <= color_d;
         rgb_q   <= rgb_d;
         step_q  <= step_d;
         ready_q <= ready_d;
         adv_q   <= adv_d;
      end
   end

   assign cmd_ready = ready_q;
   assign RGB_R     = rgb_q[2];
   assign RGB_G     = rgb_q[1];
   assign RGB_B     = rgb_q[0];
   assign step      = step_q;

endmodule

// File: tb/tb_rgb_sequencer.sv
// Scoreboard bench for rgb_sequencer: stimulus queues per-cycle expectations, a negedge monitor
// pops and compares them against the registered outputs.
module tb_rgb_sequencer;

   localparam int unsigned DW = 8;

   logic          clk;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_mode;
   logic [2:0]    cmd_color;
   logic [DW-1:0] cmd_dwell;
   logic          rgb_r;
   logic          rgb_g;
   logic          rgb_b;
   logic          step;

   int cyc    = 0;
   int errors = 0;
   int checks = 0;

   typedef struct {
      int         cyc;
      logic [2:0] rgb;
      logic       stp;
      logic       rdy;
      bit         c_rgb;
      bit         c_stp;
      string      name;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [2:0] rb_tab [6];

   rgb_sequencer #(
      .CLK_HZ       (12000000),
      .DWELL_W      (DW),
      .DWELL_DEFAULT(200)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_mode (cmd_mode),
      .cmd_color(cmd_color),
      .cmd_dwell(cmd_dwell),
      .RGB_R    (rgb_r),
      .RGB_G    (rgb_g),
      .RGB_B    (rgb_b),
      .step     (step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int c, input logic [2:0] r, input logic s, input logic rd,
                       input bit cr, input bit cs, input string n);
      exp_t e;
      e.cyc   = c;
      e.rgb   = r;
      e.stp   = s;
      e.rdy   = rd;
      e.c_rgb = cr;
      e.c_stp = cs;
      e.name  = n;
      exp_q.push_back(e);
   endtask

   // Offers one command for exactly one edge; a is the accept edge number.
   task automatic issue(input logic [1:0] m, input logic [2:0] col, input logic [DW-1:0] dw,
                        output int a);
      cmd_valid = 1'b1;
      cmd_mode  = m;
      cmd_color = col;
      cmd_dwell = dw;
      a = cyc + 1;
      tick();
      cmd_valid = 1'b0;
   endtask

   function automatic void check(input string n, input string f, input int c,
                                 input logic [2:0] got, input logic [2:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s.%s cyc=%0d got=%b want=%b", n, f, c, got, want);
      end
   endfunction

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         mon_e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL %s missed cyc=%0d now=%0d", mon_e.name, mon_e.cyc, cyc);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         mon_e = exp_q.pop_front();
         check(mon_e.name, "ready", cyc, {2'b00, cmd_ready}, {2'b00, mon_e.rdy});
         if (mon_e.c_rgb) check(mon_e.name, "rgb", cyc, {rgb_r, rgb_g, rgb_b}, mon_e.rgb);
         if (mon_e.c_stp) check(mon_e.name, "step", cyc, {2'b00, step}, {2'b00, mon_e.stp});
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int a;
      int d;
      int r;
      rb_tab    = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_mode  = 2'd0;
      cmd_color = 3'b000;
      cmd_dwell = '0;

      // Reset for three edges, cmd_ready rises on the first edge after release.
      for (int c = 1; c <= 3; c++) push(c, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, "reset");
      push(4, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, "release");
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // SOLID 011, steady with no step pulses for 100 cycles.
      issue(2'd1, 3'b011, 8'd0, a);
      push(a, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, "solid_accept");
      push(a + 1, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, "solid_load");
      for (int j = 2; j <= 101; j++) push(a + j, 3'b011, 1'b0, 1'b1, 1'b1, 1'b1, "solid_hold");
      repeat (101) tick();

      // RAINBOW dwell 4: seven colours including the wrap, step on each change.
      issue(2'd2, 3'b000, 8'd4, a);
      push(a, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, "rb_accept");
      push(a + 1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, "rb_load");
      for (int k = 0; k < 7; k++) begin
         for (int j = 0; j < 4; j++) begin
            push(a + 2 + 4 * k + j, rb_tab[k % 6], (k >= 1 && j == 0), 1'b1, 1'b1, 1'b1,
                 "rb_seq");
         end
      end
      repeat (29) tick();

      // RAINBOW dwell 3, then OFF accepted on the terminal-count edge.
      issue(2'd2, 3'b000, 8'd3, a);
      push(a, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, "pre_accept");
      push(a + 1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, "pre_load");
      push(a + 2, 3'b100, 1'b0, 1'b1, 1'b1, 1'b1, "pre_rb");
      push(a + 3, 3'b100, 1'b0, 1'b1, 1'b1, 1'b1, "pre_rb");
      repeat (3) tick();
      issue(2'd0, 3'b000, 8'd0, d);
      push(d, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, "pre_tc");
      push(d + 1, 3'b100, 1'b0, 1'b1, 1'b1, 1'b1, "pre_nostep");
      for (int j = 2; j <= 5; j++) push(d + j, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, "pre_off");
      repeat (5) tick();

      // BLINK 101 with dwell 0: toggles every cycle, step every cycle after the first.
      issue(2'd3, 3'b101, 8'd0, a);
      push(a, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, "blink_accept");
      push(a + 1, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, "blink_load");
      for (int m = 0; m < 8; m++) begin
         push(a + 2 + m, (m % 2 == 0) ? 3'b101 : 3'b000, (m >= 1), 1'b1, 1'b1, 1'b1, "blink");
      end
      repeat (9) tick();

      // Reset mid-BLINK with a command held valid throughout.
      rst       = 1'b1;
      cmd_valid = 1'b1;
      cmd_mode  = 2'd1;
      cmd_color = 3'b111;
      cmd_dwell = 8'd5;
      r = cyc + 1;
      for (int j = 0; j < 3; j++) push(r + j, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, "rst_mid");
      push(r + 3, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, "rst_release");
      repeat (3) tick();
      rst = 1'b0;
      tick();
      cmd_valid = 1'b0;
      for (int j = 4; j <= 7; j++) push(r + j, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, "rst_off");

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      while (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL %s unchecked cyc=%0d", mon_e.name, mon_e.cyc);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rgb_sequencer.md
RGB_SEQUENCER -- requirements
Module: rgb_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12000000, clock frequency in Hz, used only for documentation and default derivation.
REQ-002 SHALL have parameter DWELL_W, default 24, width of the dwell-count field.
REQ-003 SHALL have parameter DWELL_DEFAULT, default 12000000, dwell in cycles loaded at reset (1 s at 12 MHz).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port cmd_valid, input, 1, command offered.
REQ-007 SHALL have port cmd_ready, output, 1, command can be accepted this cycle.
REQ-008 SHALL have port cmd_mode, input, 2, command mode: 0 OFF, 1 SOLID, 2 RAINBOW, 3 BLINK.
REQ-009 SHALL have port cmd_color, input, 3, {R,G,B} color for SOLID and BLINK.
REQ-010 SHALL have port cmd_dwell, input, DWELL_W, cycles per step for RAINBOW and BLINK.
REQ-011 SHALL have port RGB_R, output, 1, red drive, 1 = lit.
REQ-012 SHALL have port RGB_G, output, 1, green drive, 1 = lit.
REQ-013 SHALL have port RGB_B, output, 1, blue drive, 1 = lit.
REQ-014 SHALL have port step, output, 1, one-cycle pulse on every color/phase change in RAINBOW or BLINK.

Function
REQ-015 SHALL accept a command on a cycle where cmd_valid && cmd_ready are both high; mode, color and dwell SHALL be latched on that edge.
REQ-016 SHALL deassert cmd_ready for exactly the one cycle following an accept (LOAD cycle), then reassert it.
REQ-017 SHALL hold cmd_ready high in all other cycles after reset, including mid-dwell; a new command SHALL preempt the current pattern.
REQ-018 SHALL implement FSM states OFF, LOAD, SOLID, RAINBOW, BLINK_ON, BLINK_OFF.
REQ-019 SHALL, in LOAD, clear the dwell counter, reset the rainbow index to 0, and branch on the latched mode: 0->OFF, 1->SOLID, 2->RAINBOW, 3->BLINK_ON.
REQ-020 SHALL drive RGB = 000 in OFF and BLINK_OFF, latched color in SOLID and BLINK_ON, and the table entry in RAINBOW.
REQ-021 SHALL use the RAINBOW table, index 0..5: 100, 110, 010, 011, 001, 101.
REQ-022 SHALL treat a latched dwell of 0 as 1.
REQ-023 SHALL, in RAINBOW and BLINK, count from 0 up to dwell-1; at terminal count it SHALL clear the counter, pulse step, and advance the pattern.
REQ-024 SHALL advance RAINBOW as index 5 -> 0 (wrap); SHALL toggle BLINK between BLINK_ON and BLINK_OFF.
REQ-025 SHALL NOT run the counter or pulse step in OFF, SOLID or LOAD.
REQ-026 SHALL register RGB_R/G/B and step; outputs SHALL reflect the state one cycle after the state register changes, i.e. the first new color appears two cycles after the accept edge.
REQ-027 SHALL give precedence to an accept over a simultaneous terminal count: no step pulse and no advance on that edge.
REQ-028 SHALL size the counter to DWELL_W bits; there SHALL be no overflow, because dwell never exceeds 2^DWELL_W-1.

Reset
REQ-029 SHALL, while rst is high at a clk edge, force state=OFF, counter=0, index=0, latched color=000, latched dwell=DWELL_DEFAULT, RGB=000, step=0, cmd_ready=0.
REQ-030 SHALL raise cmd_ready on the first edge after rst deasserts.
REQ-031 SHALL abort any pattern immediately on rst mid-operation, taking priority over a simultaneous accept.

Verification (use DWELL_W=8)
REQ-032 Reset: rst high 3 cycles -> RGB=000, step=0, cmd_ready=0; one cycle after release -> cmd_ready=1.
REQ-033 SOLID: accept mode=1, color=011 -> cmd_ready low 1 cycle, RGB=011 two cycles after accept, held steady with no step pulses for 100 cycles.
REQ-034 RAINBOW: accept mode=2, dwell=4 -> RGB sequence 100,110,010,011,001,101,100, each held 4 cycles, step pulse at each change including the 5->0 wrap.
REQ-035 BLINK with dwell=0: accept mode=3, color=101, dwell=0 -> RGB alternates 101/000 every cycle, step high every cycle.
REQ-036 Preempt at terminal count: RAINBOW dwell=3; accept mode=0 on an edge where the counter=2 -> no step pulse that cycle, RGB=000 two cycles later.
REQ-037 Reset mid-BLINK with cmd_valid held high -> RGB=000, cmd_ready=0 during rst, state OFF after release, no command accepted while rst is high.
